link_mm_bridge: RTL and testbench

//  Upstream stage of the link register address decoder. Converts a host Avalon-MM slave port into the

---
 rtl/link_mm_pkg.sv | 26 ++
 rtl/link_mm_bridge_if.sv | 47 ++++
 rtl/link_mm_to_timer.sv | 47 ++++
 rtl/link_mm_bridge.sv | 148 ++++++++++++++
 tb/tb_link_mm_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_mm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : link_mm_pkg                                                  |
// | Description : Shared types and widths for the link Avalon-MM bridge.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package link_mm_pkg;

  // Width of the read timeout timer; TIMEOUT_CYC must fit in it.
  localparam int TO_TIMER_W  = 8;

  // Native widths of the link register address decoder.
  localparam int LINK_ADDR_W = 17;
  localparam int LINK_DATA_W = 64;

  // Bridge transaction states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4
  } mm_br_state_e;

endpackage : link_mm_pkg
`default_nettype wire

// File: rtl/link_mm_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : link_mm_bridge_if                                            |
// | Description : Host Avalon-MM slave signals plus decoder request signals.   |
// |               slave modport = bridge view, master modport = host+decoder.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface link_mm_bridge_if
  import link_mm_pkg::*;
#(
  parameter int ADDR_W = LINK_ADDR_W,
  parameter int DATA_W = LINK_DATA_W
);

  // Host side (Avalon-MM)
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic              avs_read;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  // Decoder side
  logic [ADDR_W-1:0] mm_addr;
  logic [DATA_W-1:0] mm_wr_data;
  logic              mm_wr_en;
  logic              mm_rd_en;
  logic [DATA_W-1:0] mm_rd_data;
  logic              mm_rd_data_v;

  modport slave (
    input  avs_address, avs_write, avs_read, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    output mm_addr, mm_wr_data, mm_wr_en, mm_rd_en,
    input  mm_rd_data, mm_rd_data_v
  );

  modport master (
    output avs_address, avs_write, avs_read, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid,
    input  mm_addr, mm_wr_data, mm_wr_en, mm_rd_en,
    output mm_rd_data, mm_rd_data_v
  );

endinterface : link_mm_bridge_if
`default_nettype wire

// File: rtl/link_mm_to_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : link_mm_to_timer                                             |
// | Description : Read timeout counter. Cleared on issue, counts while         |
// |               enabled, flags expiry on its last counted cycle.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module link_mm_to_timer
  import link_mm_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_TIMER_W-1:0] LAST_CNT = TO_TIMER_W'(TIMEOUT_CYC - 1);

  logic [TO_TIMER_W-1:0] cnt_q;
  logic [TO_TIMER_W-1:0] cnt_d;

  // Next count: clear has priority; no wrap handling since every read clears first.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_TIMER_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST_CNT);

endmodule : link_mm_to_timer
`default_nettype wire

// File: rtl/link_mm_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : link_mm_bridge                                               |
// | Description : Host Avalon-MM slave to link decoder request pulses. One     |
// |               transaction outstanding; lost reads return a marker word.    |
// |               Optional macro LINK_MM_BRIDGE_ERR_CNT_EN adds err_cnt, a     |
// |               saturating timeout counter cleared by a write to addr '1.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module link_mm_bridge
  import link_mm_pkg::*;
#(
  parameter int          ADDR_W      = LINK_ADDR_W,
  parameter int          DATA_W      = LINK_DATA_W,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] TO_PATTERN  = 32'hDEAD_0BAD
) (
  input  logic              clk,
  input  logic              rst_n,
  link_mm_bridge_if.slave   bus,
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
  output logic [15:0]       err_cnt,
`endif
  output logic              rd_timeout
);

  mm_br_state_e      state_q;
  mm_br_state_e      state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              to_q;

  logic              accept;
  logic              rd_ok;
  logic              expire;
  logic              to_hit;
  logic [DATA_W-1:0] to_word;

  // A request is only taken in IDLE; a write wins over a simultaneous read.
  assign accept = (state_q == IDLE) && (bus.avs_write || bus.avs_read);
  assign rd_ok  = (state_q == RD_WAIT) && bus.mm_rd_data_v;
  // Real data arriving in the expiry cycle takes precedence over the timeout.
  assign to_hit = expire && !bus.mm_rd_data_v;

  link_mm_to_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_to_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == RD_ISSUE),
    .en_i     (state_q == RD_WAIT),
    .expire_o (expire)
  );

  // Marker word returned for a lost read: pattern on top, captured address below.
  always_comb begin
    to_word                 = '0;
    to_word[DATA_W-1 -: 32] = TO_PATTERN;
    to_word[ADDR_W-1:0]     = addr_q;
  end

  // Transaction sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.avs_write) begin
          state_d = WR;
        end else if (bus.avs_read) begin
          state_d = RD_ISSUE;
        end
      end
      WR:       state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_ok || expire) begin
          state_d = RESP;
        end
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address/data capture on acceptance, held until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.avs_address;
      wdata_q <= bus.avs_writedata;
    end
  end

  // Response register: decoder data or timeout marker, plus the timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      to_q <= to_hit;
      if (rd_ok) begin
        rdata_q <= bus.mm_rd_data;
      end else if (to_hit) begin
        rdata_q <= to_word;
      end
    end
  end

`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating timeout count; a write to the all-ones address clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if ((state_q == WR) && (&addr_q)) begin
      err_cnt_q <= '0;
    end else if (to_hit && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign bus.avs_waitrequest   = (state_q != IDLE) || !rst_n;
  assign bus.avs_readdata      = rdata_q;
  assign bus.avs_readdatavalid = (state_q == RESP);
  assign bus.mm_addr           = addr_q;
  assign bus.mm_wr_data        = wdata_q;
  assign bus.mm_wr_en          = (state_q == WR);
  assign bus.mm_rd_en          = (state_q == RD_ISSUE);
  assign rd_timeout            = to_q;

endmodule : link_mm_bridge
`default_nettype wire

// File: tb/tb_link_mm_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_link_mm_bridge                                            |
// | Description : Self-checking bench for link_mm_bridge with scoreboard       |
// |               queues for expected reads and writes.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_link_mm_bridge;

  localparam int          ADDR_W      = 17;
  localparam int          DATA_W      = 64;
  localparam int          TIMEOUT_CYC = 64;
  localparam logic [31:0] TO_PAT      = 32'hDEAD_0BAD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rd_timeout;
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  link_mm_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  link_mm_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_PATTERN  (TO_PAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .rd_timeout (rd_timeout)
  );

  typedef struct { logic [63:0] data; bit tmo; } rd_exp_t;
  typedef struct { logic [16:0] addr; logic [63:0] data; } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      n_cmp = 0;
  int      n_mis = 0;

  // Issue one read; decoder answers dv_delay cycles after mm_rd_en (-1: never).
  task automatic run_read(input logic [16:0] addr, input int dv_delay, input logic [63:0] dv_data,
                          output logic [63:0] rdata, output logic [63:0] rdata_hold,
                          output int lat, output int n_rdv, output int n_to, output int n_to_off);
    int c_rd;
    int w;
    rdata = '0; rdata_hold = '0; lat = -1; n_rdv = 0; n_to = 0; n_to_off = 0; c_rd = -1;
    @(negedge clk);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    w = 0;
    while (bus.avs_waitrequest && w < 200) begin
      @(negedge clk);
      w++;
    end
    for (int c = 1; c <= TIMEOUT_CYC + 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.avs_read = 1'b0;
      if (bus.mm_rd_en && c_rd < 0) c_rd = c;
      if (bus.avs_readdatavalid) begin
        n_rdv++;
        if (lat < 0) begin
          lat   = c;
          rdata = bus.avs_readdata;
        end
      end
      if (rd_timeout) begin
        n_to++;
        if (!bus.avs_readdatavalid) n_to_off++;
      end
      if (lat >= 0 && c == lat + 2) rdata_hold = bus.avs_readdata;
      bus.mm_rd_data_v = (dv_delay >= 0 && c_rd >= 0 && c == c_rd + dv_delay);
      bus.mm_rd_data   = bus.mm_rd_data_v ? dv_data : 64'h0;
      if (lat >= 0 && c >= lat + 3) break;
    end
    bus.avs_read     = 1'b0;
    bus.mm_rd_data_v = 1'b0;
  endtask

  // Issue one write and watch the decoder side for a few cycles.
  task automatic run_write(input logic [16:0] addr, input logic [63:0] data,
                           output int c_wr, output logic [16:0] a_obs, output logic [63:0] d_obs,
                           output int n_wr, output int n_wait);
    int w;
    c_wr = -1; a_obs = '0; d_obs = '0; n_wr = 0; n_wait = 0;
    @(negedge clk);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    w = 0;
    while (bus.avs_waitrequest && w < 200) begin
      @(negedge clk);
      w++;
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.avs_write = 1'b0;
      if (bus.avs_waitrequest) n_wait++;
      if (bus.mm_wr_en) begin
        n_wr++;
        if (c_wr < 0) begin
          c_wr  = c;
          a_obs = bus.mm_addr;
          d_obs = bus.mm_wr_data;
        end
      end
    end
    bus.avs_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_mis++; $display("FAIL reset_waitreq: got %b want 1", bus.avs_waitrequest); end
    n_cmp++; if ({bus.mm_wr_en, bus.mm_rd_en, bus.avs_readdatavalid, rd_timeout} !== 4'b0000) begin
      n_mis++; $display("FAIL reset_pulses: got %b want 0000", {bus.mm_wr_en, bus.mm_rd_en, bus.avs_readdatavalid, rd_timeout}); end
    n_cmp++; if ({bus.mm_addr, bus.mm_wr_data, bus.avs_readdata} !== '0) begin
      n_mis++; $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", bus.mm_addr, bus.mm_wr_data, bus.avs_readdata); end
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    n_cmp++; if (err_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.avs_waitrequest !== 1'b0) begin n_mis++; $display("FAIL idle_waitreq: got %b want 0", bus.avs_waitrequest); end
  endtask

  task automatic test_write();
    int c_wr, n_wr, n_wait;
    logic [16:0] a;
    logic [63:0] d;
    wr_exp_t e;
    wr_q.push_back('{addr: 17'h04010, data: 64'h1122_3344_5566_7788});
    run_write(17'h04010, 64'h1122_3344_5566_7788, c_wr, a, d, n_wr, n_wait);
    e = wr_q.pop_front();
    n_cmp++; if (a !== e.addr) begin n_mis++; $display("FAIL write_addr: got %h want %h", a, e.addr); end
    n_cmp++; if (d !== e.data) begin n_mis++; $display("FAIL write_data: got %h want %h", d, e.data); end
    n_cmp++; if (n_wr !== 1 || c_wr !== 1) begin n_mis++; $display("FAIL write_pulse: count %0d at %0d want 1 at 1", n_wr, c_wr); end
    n_cmp++; if (n_wait !== 1) begin n_mis++; $display("FAIL write_waitreq: got %0d cycles want 1", n_wait); end
  endtask

  task automatic test_back_to_back();
    int c_first, c_second, n_wr, w;
    bit wait_c1, wait_c2;
    wr_exp_t e;
    c_first = -1; c_second = -1; n_wr = 0; wait_c1 = 1'b0; wait_c2 = 1'b1;
    wr_q.push_back('{addr: 17'h00A01, data: 64'h0000_0000_0000_0001});
    wr_q.push_back('{addr: 17'h00A02, data: 64'hFFFF_0000_FFFF_0002});
    @(negedge clk);
    bus.avs_address = 17'h00A01; bus.avs_writedata = 64'h0000_0000_0000_0001; bus.avs_write = 1'b1;
    w = 0;
    while (bus.avs_waitrequest && w < 200) begin @(negedge clk); w++; end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) wait_c1 = bus.avs_waitrequest;
      if (c == 2) wait_c2 = bus.avs_waitrequest;
      if (bus.mm_wr_en) begin
        n_wr++;
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          n_cmp++; if ({bus.mm_addr, bus.mm_wr_data} !== {e.addr, e.data}) begin
            n_mis++; $display("FAIL b2b_write: got %h/%h want %h/%h", bus.mm_addr, bus.mm_wr_data, e.addr, e.data); end
        end
        if (c_first < 0) c_first = c; else if (c_second < 0) c_second = c;
      end
      if (c == 1) begin bus.avs_address = 17'h00A02; bus.avs_writedata = 64'hFFFF_0000_FFFF_0002; end
      if (c == 3) bus.avs_write = 1'b0;
    end
    bus.avs_write = 1'b0;
    n_cmp++; if ({wait_c1, wait_c2} !== 2'b10) begin n_mis++; $display("FAIL b2b_waitreq: got %b want 10", {wait_c1, wait_c2}); end
    n_cmp++; if (n_wr !== 2 || c_first !== 1 || c_second !== 3) begin
      n_mis++; $display("FAIL b2b_timing: %0d pulses at %0d,%0d want 2 at 1,3", n_wr, c_first, c_second); end
    n_cmp++; if (wr_q.size() !== 0) begin n_mis++; $display("FAIL b2b_left: got %0d want 0", wr_q.size()); wr_q.delete(); end
  endtask

  task automatic test_read();
    logic [63:0] rd, hold;
    int lat, n_rdv, n_to, n_off;
    rd_exp_t e;
    rd_q.push_back('{data: 64'h0000_0000_0000_CAFE, tmo: 1'b0});
    run_read(17'h08000, 3, 64'h0000_0000_0000_CAFE, rd, hold, lat, n_rdv, n_to, n_off);
    e = rd_q.pop_front();
    n_cmp++; if (rd !== e.data) begin n_mis++; $display("FAIL read_data: got %h want %h", rd, e.data); end
    n_cmp++; if (lat !== 5) begin n_mis++; $display("FAIL read_latency: got %0d want 5", lat); end
    n_cmp++; if (n_rdv !== 1) begin n_mis++; $display("FAIL read_pulses: got %0d want 1", n_rdv); end
    n_cmp++; if (n_to !== (e.tmo ? 1 : 0)) begin n_mis++; $display("FAIL read_timeout: got %0d want 0", n_to); end
  endtask

  task automatic test_timeout();
    logic [63:0] rd, hold;
    int lat, n_rdv, n_to, n_off;
    rd_exp_t e;
    rd_q.push_back('{data: 64'hDEAD_0BAD_0001_F000, tmo: 1'b1});
    run_read(17'h1F000, -1, 64'h0, rd, hold, lat, n_rdv, n_to, n_off);
    e = rd_q.pop_front();
    n_cmp++; if (rd !== e.data) begin n_mis++; $display("FAIL timeout_data: got %h want %h", rd, e.data); end
    n_cmp++; if (lat !== TIMEOUT_CYC + 2) begin n_mis++; $display("FAIL timeout_latency: got %0d want %0d", lat, TIMEOUT_CYC + 2); end
    n_cmp++; if (n_to !== 1 || n_off !== 0) begin n_mis++; $display("FAIL timeout_pulse: got %0d (%0d unaligned) want 1 (0)", n_to, n_off); end
    n_cmp++; if (n_rdv !== 1) begin n_mis++; $display("FAIL timeout_rdv: got %0d want 1", n_rdv); end
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    n_cmp++; if (err_cnt !== 16'd1) begin n_mis++; $display("FAIL timeout_err_cnt: got %0d want 1", err_cnt); end
`endif
  endtask

  task automatic test_timeout_race();
    logic [63:0] rd, hold;
    int lat, n_rdv, n_to, n_off;
    rd_exp_t e;
    rd_q.push_back('{data: 64'h0123_4567_89AB_CDEF, tmo: 1'b0});
    run_read(17'h00777, TIMEOUT_CYC, 64'h0123_4567_89AB_CDEF, rd, hold, lat, n_rdv, n_to, n_off);
    e = rd_q.pop_front();
    n_cmp++; if (rd !== e.data) begin n_mis++; $display("FAIL race_data: got %h want %h", rd, e.data); end
    n_cmp++; if (n_to !== 0) begin n_mis++; $display("FAIL race_timeout: got %0d want 0", n_to); end
    n_cmp++; if (lat !== TIMEOUT_CYC + 2) begin n_mis++; $display("FAIL race_latency: got %0d want %0d", lat, TIMEOUT_CYC + 2); end
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    n_cmp++; if (err_cnt !== 16'd1) begin n_mis++; $display("FAIL race_err_cnt: got %0d want 1", err_cnt); end
`endif
  endtask

  task automatic test_late_data();
    logic [63:0] rd, hold;
    int lat, n_rdv, n_to, n_off;
    rd_exp_t e;
    rd_q.push_back('{data: {TO_PAT, 15'd0, 17'h12345}, tmo: 1'b1});
    run_read(17'h12345, TIMEOUT_CYC + 1, 64'h7777_7777_7777_7777, rd, hold, lat, n_rdv, n_to, n_off);
    e = rd_q.pop_front();
    n_cmp++; if (rd !== e.data || n_to !== 1) begin n_mis++; $display("FAIL late_timeout: got %h/%0d want %h/1", rd, n_to, e.data); end
    n_cmp++; if (hold !== e.data) begin n_mis++; $display("FAIL late_ignored: got %h want %h", hold, e.data); end
    n_cmp++; if (n_rdv !== 1) begin n_mis++; $display("FAIL late_rdv: got %0d want 1", n_rdv); end
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    n_cmp++; if (err_cnt !== 16'd2) begin n_mis++; $display("FAIL late_err_cnt: got %0d want 2", err_cnt); end
`endif
  endtask

  task automatic test_both_reset();
    int c_wr, c_rd, n_rdv, n_to, w;
    logic [16:0] a;
    c_wr = -1; c_rd = -1; n_rdv = 0; n_to = 0; a = '0;
    @(negedge clk);
    bus.avs_address = 17'h00123; bus.avs_writedata = 64'hA5A5_5A5A_A5A5_5A5A;
    bus.avs_write = 1'b1; bus.avs_read = 1'b1;
    w = 0;
    while (bus.avs_waitrequest && w < 200) begin @(negedge clk); w++; end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.avs_write = 1'b0;
      if (bus.mm_wr_en && c_wr < 0) begin c_wr = c; a = bus.mm_addr; end
      if (bus.mm_rd_en && c_rd < 0) c_rd = c;
      if (c == 3) bus.avs_read = 1'b0;
    end
    n_cmp++; if (c_wr !== 1 || a !== 17'h00123) begin n_mis++; $display("FAIL both_write_first: at %0d addr %h want 1 00123", c_wr, a); end
    n_cmp++; if (c_rd !== 3) begin n_mis++; $display("FAIL both_read_next: got %0d want 3", c_rd); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_mis++; $display("FAIL midrst_waitreq: got %b want 1", bus.avs_waitrequest); end
    n_cmp++; if ({bus.mm_wr_en, bus.mm_rd_en, bus.avs_readdatavalid, rd_timeout} !== 4'b0000) begin
      n_mis++; $display("FAIL midrst_pulses: got %b want 0000", {bus.mm_wr_en, bus.mm_rd_en, bus.avs_readdatavalid, rd_timeout}); end
    n_cmp++; if ({bus.mm_addr, bus.mm_wr_data, bus.avs_readdata} !== '0) begin
      n_mis++; $display("FAIL midrst_data: addr %h wdata %h rdata %h want 0", bus.mm_addr, bus.mm_wr_data, bus.avs_readdata); end
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    n_cmp++; if (err_cnt !== 16'd0) begin n_mis++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < TIMEOUT_CYC + 8; c++) begin
      @(negedge clk);
      if (bus.avs_readdatavalid) n_rdv++;
      if (rd_timeout) n_to++;
    end
    n_cmp++; if (n_rdv !== 0 || n_to !== 0) begin n_mis++; $display("FAIL midrst_no_resp: rdv %0d to %0d want 0 0", n_rdv, n_to); end
  endtask

  task automatic test_stray();
    logic [63:0] rd, hold;
    int lat, n_rdv, n_to, n_off, n_stray;
    bit data_moved;
    rd_exp_t e;
    n_stray = 0; data_moved = 1'b0;
    @(negedge clk);
    bus.mm_rd_data = 64'h5555_AAAA_5555_AAAA; bus.mm_rd_data_v = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mm_rd_data_v = 1'b0;
      if (bus.avs_readdatavalid) n_stray++;
      if (bus.avs_readdata !== 64'h0) data_moved = 1'b1;
    end
    n_cmp++; if (n_stray !== 0) begin n_mis++; $display("FAIL stray_rdv: got %0d want 0", n_stray); end
    n_cmp++; if (data_moved !== 1'b0) begin n_mis++; $display("FAIL stray_data: got %h want 0", bus.avs_readdata); end
    rd_q.push_back('{data: 64'h0000_0000_0000_BEEF, tmo: 1'b0});
    run_read(17'h00042, 1, 64'h0000_0000_0000_BEEF, rd, hold, lat, n_rdv, n_to, n_off);
    e = rd_q.pop_front();
    n_cmp++; if (rd !== e.data || lat !== 3) begin n_mis++; $display("FAIL stray_next_read: got %h at %0d want %h at 3", rd, lat, e.data); end
  endtask

`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
  task automatic test_err_clear();
    logic [63:0] rd, hold, d;
    logic [16:0] a;
    int lat, n_rdv, n_to, n_off, c_wr, n_wr, n_wait;
    run_read(17'h00ABC, -1, 64'h0, rd, hold, lat, n_rdv, n_to, n_off);
    n_cmp++; if (err_cnt !== 16'd1) begin n_mis++; $display("FAIL errclr_pre: got %0d want 1", err_cnt); end
    run_write(17'h1FFFF, 64'h0000_0000_0000_00C1, c_wr, a, d, n_wr, n_wait);
    n_cmp++; if (n_wr !== 1 || a !== 17'h1FFFF) begin n_mis++; $display("FAIL errclr_fwd: %0d pulses addr %h want 1 1ffff", n_wr, a); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_mis++; $display("FAIL errclr_post: got %0d want 0", err_cnt); end
  endtask
`endif

  initial begin
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    bus.avs_writedata = '0;
    bus.mm_rd_data    = '0;
    bus.mm_rd_data_v  = 1'b0;
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_timeout();
    test_timeout_race();
    test_late_data();
    test_both_reset();
    test_stray();
`ifdef LINK_MM_BRIDGE_ERR_CNT_EN
    test_err_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_link_mm_bridge
`default_nettype wire
